// File: rtl/rom_arbiter.sv
// rtl/rom_arbiter.sv - two-port arbiter/sequencer sharing one combinational ROM
//
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   req0/adr0         : requester 0 level request and address (held while req0=1)
//   req1/adr1         : requester 1 level request and address (held while req1=1)
//   gnt0/gnt1         : one-cycle pulse, request accepted (first cycle of READ)
//   vld0/vld1         : one-cycle pulse, rdata carries that requester's word
//   rdata             : last captured ROM word, shared by both requesters
//   busy              : high while the FSM is in READ
//   ROM_adr/ROM_data  : registered address to / combinational data from the ROM
//
// Configuration macro: ROM_ARB_RR_EN
//   defined   -> round-robin tie-break (requester other than the last owner wins)
//   undefined -> fixed priority, requester 0 wins every tie
module rom_arbiter #(
  parameter int ADR_W = 3,
  parameter int DAT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [ADR_W-1:0] adr0,
  input  logic             req1,
  input  logic [ADR_W-1:0] adr1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             vld0,
  output logic             vld1,
  output logic [DAT_W-1:0] rdata,
  output logic             busy,
  output logic [ADR_W-1:0] ROM_adr,
  input  logic [DAT_W-1:0] ROM_data
);

  typedef enum logic {IDLE = 1'b0, READ = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;   // 0: requester 0 owns the access
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] rdata_q, rdata_d;
  logic             vld0_q, vld0_d;
  logic             vld1_q, vld1_d;
  logic             win1;               // requester 1 wins this arbitration

`ifdef ROM_ARB_RR_EN
  logic             last_q, last_d;     // owner of the most recent completed access

  // On a tie the requester that did not go last wins.
  assign win1 = req1 & (~req0 | ~last_q);
`else
  assign win1 = req1 & ~req0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      adr_q   <= '0;
      rdata_q <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
`ifdef ROM_ARB_RR_EN
      last_q  <= 1'b1;  // makes requester 0 win the first tie
`endif
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      adr_q   <= adr_d;
      rdata_q <= rdata_d;
      vld0_q  <= vld0_d;
      vld1_q  <= vld1_d;
`ifdef ROM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    adr_d   = adr_q;
    rdata_d = rdata_q;
    vld0_d  = 1'b0;
    vld1_d  = 1'b0;
`ifdef ROM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = win1;
          adr_d   = win1 ? adr1 : adr0;
          state_d = READ;
        end
      end
      READ: begin
        // Requests are ignored here; ROM_adr has been stable for a full cycle.
        rdata_d = ROM_data;
        vld0_d  = ~owner_q;
        vld1_d  = owner_q;
`ifdef ROM_ARB_RR_EN
        last_d  = owner_q;
`endif
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic: the grant pulse is exactly the READ cycle of the owner.
  always_comb begin
    busy = (state_q == READ);
    gnt0 = busy & ~owner_q;
    gnt1 = busy & owner_q;
  end

  assign vld0    = vld0_q;
  assign vld1    = vld1_q;
  assign rdata   = rdata_q;
  assign ROM_adr = adr_q;

endmodule

// File: tb/tb_rom_arbiter.sv
// tb/tb_rom_arbiter.sv - directed self-checking bench for rom_arbiter
module tb_rom_arbiter;

`ifdef ROM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] adr0, adr1;
  logic       gnt0, gnt1, vld0, vld1, busy;
  logic [3:0] rdata;
  logic [2:0] ROM_adr;
  logic [3:0] ROM_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // 8x4 ROM contents
  function automatic logic [3:0] rom_val(input logic [2:0] a);
    case (a)
      3'd0: rom_val = 4'hA;
      3'd1: rom_val = 4'h3;
      3'd2: rom_val = 4'hC;
      3'd3: rom_val = 4'h6;
      3'd4: rom_val = 4'hF;
      3'd5: rom_val = 4'h1;
      3'd6: rom_val = 4'h8;
      default: rom_val = 4'hD;
    endcase
  endfunction

  assign ROM_data = rom_val(ROM_adr);

  rom_arbiter #(.ADR_W(3), .DAT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .adr0(adr0), .req1(req1), .adr1(adr1),
    .gnt0(gnt0), .gnt1(gnt1), .vld0(vld0), .vld1(vld1),
    .rdata(rdata), .busy(busy),
    .ROM_adr(ROM_adr), .ROM_data(ROM_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic saw_vld;
    rst_n = 1'b0; req0 = 0; req1 = 0; adr0 = 0; adr1 = 0;
    #12;
    checks++;
    if ({busy, gnt0, gnt1, vld0, vld1, ROM_adr, rdata} !== 12'h0) begin
      errors++;
      $display("FAIL reset_state: got %b want 0", {busy, gnt0, gnt1, vld0, vld1, ROM_adr, rdata});
    end
    @(negedge clk); rst_n = 1'b1;
    step();
    req0 = 1; adr0 = 3'd5;
    step();
    checks++;
    if ({busy, gnt0, ROM_adr} !== {1'b1, 1'b1, 3'd5}) begin
      errors++;
      $display("FAIL reset_pre_read: got %b want %b", {busy, gnt0, ROM_adr}, {1'b1, 1'b1, 3'd5});
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, gnt0, gnt1, vld0, vld1, ROM_adr, rdata} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid_read: got %b want 0", {busy, gnt0, gnt1, vld0, vld1, ROM_adr, rdata});
    end
    req0 = 0;
    @(negedge clk); rst_n = 1'b1;
    saw_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      saw_vld = saw_vld | vld0 | vld1 | busy;
    end
    checks++;
    if (saw_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort_no_vld: got %b want 0", saw_vld);
    end
  endtask

  task automatic test_single();
    req0 = 1; adr0 = 3'd3;
    step();
    req0 = 0;
    checks++;
    if ({gnt0, gnt1, busy, vld0, vld1, ROM_adr} !== {5'b10100, 3'd3}) begin
      errors++;
      $display("FAIL single_grant: got %b want %b", {gnt0, gnt1, busy, vld0, vld1, ROM_adr}, {5'b10100, 3'd3});
    end
    step();
    checks++;
    if ({gnt0, gnt1, busy, vld0, vld1, rdata} !== {5'b00010, 4'h6}) begin
      errors++;
      $display("FAIL single_vld: got %b want %b", {gnt0, gnt1, busy, vld0, vld1, rdata}, {5'b00010, 4'h6});
    end
    step();
    checks++;
    if ({gnt0, gnt1, busy, vld0, vld1, rdata, ROM_adr} !== {5'b00000, 4'h6, 3'd3}) begin
      errors++;
      $display("FAIL single_hold: got %b want %b", {gnt0, gnt1, busy, vld0, vld1, rdata, ROM_adr}, {5'b00000, 4'h6, 3'd3});
    end
  endtask

  task automatic test_tie();
    apply_reset();
    req0 = 1; adr0 = 3'd7; req1 = 1; adr1 = 3'd0;
    step();
    checks++;
    if ({gnt0, gnt1, ROM_adr} !== {2'b10, 3'd7}) begin
      errors++;
      $display("FAIL tie_first_gnt: got %b want %b", {gnt0, gnt1, ROM_adr}, {2'b10, 3'd7});
    end
    step();
    checks++;
    if ({vld0, vld1, gnt0, gnt1, rdata} !== {4'b1000, 4'hD}) begin
      errors++;
      $display("FAIL tie_first_vld: got %b want %b", {vld0, vld1, gnt0, gnt1, rdata}, {4'b1000, 4'hD});
    end
    step();
    checks++;
    if ({gnt0, gnt1, ROM_adr} !== {~RR, RR, (RR ? 3'd0 : 3'd7)}) begin
      errors++;
      $display("FAIL tie_second_gnt: got %b want %b", {gnt0, gnt1, ROM_adr}, {~RR, RR, (RR ? 3'd0 : 3'd7)});
    end
    step();
    checks++;
    if ({vld0, vld1, rdata} !== {~RR, RR, (RR ? 4'hA : 4'hD)}) begin
      errors++;
      $display("FAIL tie_second_vld: got %b want %b", {vld0, vld1, rdata}, {~RR, RR, (RR ? 4'hA : 4'hD)});
    end
    step();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL tie_third_gnt: got %b want 10", {gnt0, gnt1});
    end
    req0 = 0; req1 = 0;
    step();
    step();
  endtask

  task automatic test_sweep();
    for (int a = 7; a >= 0; a--) begin
      req1 = 1; adr1 = 3'(a);
      step();
      req1 = 0;
      checks++;
      if ({gnt1, gnt0, ROM_adr} !== {2'b10, 3'(a)}) begin
        errors++;
        $display("FAIL sweep_gnt a=%0d: got %b want %b", a, {gnt1, gnt0, ROM_adr}, {2'b10, 3'(a)});
      end
      step();
      checks++;
      if ({vld1, vld0, rdata} !== {2'b10, rom_val(3'(a))}) begin
        errors++;
        $display("FAIL sweep_vld a=%0d: got %b want %b", a, {vld1, vld0, rdata}, {2'b10, rom_val(3'(a))});
      end
    end
  endtask

  task automatic test_back_to_back();
    int ng;
    ng = 0;
    req1 = 1; adr1 = 3'd2;
    for (int i = 0; i < 6; i++) begin
      step();
      ng += int'(gnt1);
      checks++;
      if ({gnt1, busy} !== {2{(i % 2) == 0}}) begin
        errors++;
        $display("FAIL held_cycle%0d: got gnt1/busy=%b want %b", i, {gnt1, busy}, {2{(i % 2) == 0}});
      end
    end
    req1 = 0;
    checks++;
    if (ng !== 3) begin
      errors++;
      $display("FAIL held_gnt_count: got %0d want 3", ng);
    end
    step();
  endtask

  task automatic test_priority();
    int n0, n1;
    n0 = 0; n1 = 0;
    apply_reset();
    req0 = 1; adr0 = 3'd1; req1 = 1; adr1 = 3'd4;
    for (int i = 0; i < 8; i++) begin
      step();
      n0 += int'(gnt0);
      n1 += int'(gnt1);
    end
    req0 = 0; req1 = 0;
    checks++;
    if (n0 !== (RR ? 2 : 4) || n1 !== (RR ? 2 : 0)) begin
      errors++;
      $display("FAIL priority_counts: got gnt0=%0d gnt1=%0d want gnt0=%0d gnt1=%0d",
               n0, n1, (RR ? 2 : 4), (RR ? 2 : 0));
    end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_sweep();
    test_back_to_back();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
